// File: rtl/ncpu32k_wb_rr_arbiter.sv
// Round-robin writeback arbiter: picks one FU writeback channel per cycle
// and registers it onto the single ROB writeback port / bypass network.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   flush              - discard in-flight writeback, block new grants
//   fu_wb_*            - per-way valid/ready channel with data, tag, ROB id
//   rob_wb_*           - registered writeback output with ROB backpressure
//   rob_wb_grant       - one-hot source way of the current output entry
//   perf_*_cnt         - conflict / stall counters (zero unless enabled)
//
// Optional: define NCPU_WB_ARB_PERF_EN to instantiate the perf counters.

module ncpu32k_wb_rr_arbiter #(
    parameter int WAYS      = 5,
    parameter int DW        = 32,
    parameter int TAG_WIDTH = 5,
    parameter int ID_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [WAYS-1:0]           fu_wb_BVALID,
    output logic [WAYS-1:0]           fu_wb_BREADY,
    input  logic [WAYS*DW-1:0]        fu_wb_BDATA,
    input  logic [WAYS*TAG_WIDTH-1:0] fu_wb_BTAG,
    input  logic [WAYS*ID_WIDTH-1:0]  fu_wb_id,
    output logic                      rob_wb_BVALID,
    input  logic                      rob_wb_BREADY,
    output logic [DW-1:0]             rob_wb_BDATA,
    output logic [TAG_WIDTH-1:0]      rob_wb_BTAG,
    output logic [ID_WIDTH-1:0]       rob_wb_id,
    output logic [WAYS-1:0]           rob_wb_grant,
    output logic [31:0]               perf_conflict_cnt,
    output logic [31:0]               perf_stall_cnt
);

    logic [WAYS-1:0]      r_rr_ptr;
    logic                 r_valid;
    logic [DW-1:0]        r_data;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [ID_WIDTH-1:0]  r_id;
    logic [WAYS-1:0]      r_grant;

    logic                 w_load;
    logic [WAYS-1:0]      w_req_hi;
    logic [WAYS-1:0]      w_pick;
    logic [WAYS-1:0]      w_grant;
    logic [DW-1:0]        w_data;
    logic [TAG_WIDTH-1:0] w_tag;
    logic [ID_WIDTH-1:0]  w_id;

    // Output register refills in the same cycle it drains.
    assign w_load = ~flush & (~r_valid | rob_wb_BREADY);

    // Requests at or above the pointer take precedence; if none, wrap to
    // the full request vector. Lowest set bit of the chosen vector wins.
    assign w_req_hi = fu_wb_BVALID & ~(r_rr_ptr - WAYS'(1));
    assign w_pick   = (|w_req_hi) ? w_req_hi : fu_wb_BVALID;
    assign w_grant  = w_pick & (~w_pick + WAYS'(1));

    assign fu_wb_BREADY = w_grant & {WAYS{w_load}};

    always_comb begin
        w_data = '0;
        w_tag  = '0;
        w_id   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_grant[i]) begin
                w_data = fu_wb_BDATA[i*DW +: DW];
                w_tag  = fu_wb_BTAG[i*TAG_WIDTH +: TAG_WIDTH];
                w_id   = fu_wb_id[i*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= WAYS'(1);
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_tag    <= '0;
            r_id     <= '0;
            r_grant  <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_grant  <= '0;
        end else if (w_load) begin
            r_valid  <= |w_grant;
            r_grant  <= w_grant;
            if (|w_grant) begin
                r_data   <= w_data;
                r_tag    <= w_tag;
                r_id     <= w_id;
                r_rr_ptr <= {w_grant[WAYS-2:0], w_grant[WAYS-1]};
            end
        end
    end

    assign rob_wb_BVALID = r_valid;
    assign rob_wb_BDATA  = r_data;
    assign rob_wb_BTAG   = r_tag;
    assign rob_wb_id     = r_id;
    assign rob_wb_grant  = r_grant;

`ifdef NCPU_WB_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_multi;

    // More than one valid way: clearing the lowest set bit leaves others.
    assign w_multi = |(fu_wb_BVALID & (fu_wb_BVALID - WAYS'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_load & (|w_grant) & w_multi)
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if (r_valid & ~rob_wb_BREADY & ~flush)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_conflict_cnt = r_conflict_cnt;
    assign perf_stall_cnt    = r_stall_cnt;
`else
    assign perf_conflict_cnt = 32'd0;
    assign perf_stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_ncpu32k_wb_rr_arbiter.sv
// Bench for ncpu32k_wb_rr_arbiter: vector table plus a scoreboard of
// expected writebacks, followed by hand-written reset/flush and latency cases.

module tb_ncpu32k_wb_rr_arbiter;

    localparam int WAYS = 5;
    localparam int DW   = 32;
    localparam int TW   = 5;
    localparam int IW   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [WAYS-1:0]    fu_valid;
    logic [WAYS-1:0]    fu_ready;
    logic [WAYS*DW-1:0] fu_data;
    logic [WAYS*TW-1:0] fu_tag;
    logic [WAYS*IW-1:0] fu_id;
    logic               rob_valid;
    logic               rob_ready;
    logic [DW-1:0]      rob_data;
    logic [TW-1:0]      rob_tag;
    logic [IW-1:0]      rob_id;
    logic [WAYS-1:0]    rob_grant;
    logic [31:0]        conflict_cnt;
    logic [31:0]        stall_cnt;

    logic [DW-1:0] pd  [WAYS] = '{32'h0000_00A0, 32'h0000_0011, 32'hDEAD_BEEF,
                                  32'h3333_3333, 32'h4444_4444};
    logic [TW-1:0] pt  [WAYS] = '{5'h10, 5'h01, 5'h07, 5'h13, 5'h1F};
    logic [IW-1:0] pid [WAYS] = '{4'h1, 4'h5, 4'h3, 4'hC, 4'hF};

    assign fu_data = {pd[4], pd[3], pd[2], pd[1], pd[0]};
    assign fu_tag  = {pt[4], pt[3], pt[2], pt[1], pt[0]};
    assign fu_id   = {pid[4], pid[3], pid[2], pid[1], pid[0]};

    always #5 clk = ~clk;

    ncpu32k_wb_rr_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .fu_wb_BVALID      (fu_valid),
        .fu_wb_BREADY      (fu_ready),
        .fu_wb_BDATA       (fu_data),
        .fu_wb_BTAG        (fu_tag),
        .fu_wb_id          (fu_id),
        .rob_wb_BVALID     (rob_valid),
        .rob_wb_BREADY     (rob_ready),
        .rob_wb_BDATA      (rob_data),
        .rob_wb_BTAG       (rob_tag),
        .rob_wb_id         (rob_id),
        .rob_wb_grant      (rob_grant),
        .perf_conflict_cnt (conflict_cnt),
        .perf_stall_cnt    (stall_cnt)
    );

    typedef struct {
        logic            r;
        logic            f;
        logic            rdy;
        logic [WAYS-1:0] v;
        logic [WAYS-1:0] eb;
        logic            ev;
    } vec_t;

    typedef struct {
        logic [DW-1:0]   d;
        logic [TW-1:0]   t;
        logic [IW-1:0]   id;
        logic [WAYS-1:0] g;
    } out_t;

    vec_t vq[$];
    out_t sbq[$];
    out_t held;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic f, input logic rdy,
                       input logic [WAYS-1:0] v, input logic [WAYS-1:0] eb,
                       input logic ev);
        vec_t x;
        x.r = r; x.f = f; x.rdy = rdy; x.v = v; x.eb = eb; x.ev = ev;
        vq.push_back(x);
    endtask

    function automatic out_t rec_of(input logic [WAYS-1:0] g);
        out_t o;
        o = '{default: '0};
        for (int i = 0; i < WAYS; i++)
            if (g[i]) o = '{pd[i], pt[i], pid[i], g};
        return o;
    endfunction

    initial begin
        logic        pre_ov;
        logic [31:0] m_stall;
        logic [31:0] m_conf;
        int          cyc;
        vec_t        x;
        out_t        e;

        rst = 1'b1; flush = 1'b0; rob_ready = 1'b0; fu_valid = '0;
        pre_ov = 1'b0; m_stall = 0; m_conf = 0;
        held = '{default: '0};

        //  rst  fl   rdy  valid     bready    bvalid
        add(1, 0, 0, 5'b00000, 5'b00000, 0);
        add(1, 0, 0, 5'b00000, 5'b00000, 0);
        add(0, 0, 1, 5'b00100, 5'b00100, 1);
        add(0, 0, 1, 5'b00000, 5'b00000, 0);
        add(1, 0, 0, 5'b00000, 5'b00000, 0);
        add(0, 0, 1, 5'b11111, 5'b00001, 1);
        add(0, 0, 1, 5'b11111, 5'b00010, 1);
        add(0, 0, 1, 5'b11111, 5'b00100, 1);
        add(0, 0, 1, 5'b11111, 5'b01000, 1);
        add(0, 0, 1, 5'b11111, 5'b10000, 1);
        add(0, 0, 1, 5'b11111, 5'b00001, 1);
        add(0, 0, 1, 5'b11111, 5'b00010, 1);
        add(0, 0, 0, 5'b11111, 5'b00000, 1);
        add(0, 0, 0, 5'b11111, 5'b00000, 1);
        add(0, 0, 0, 5'b11111, 5'b00000, 1);
        add(0, 0, 1, 5'b11111, 5'b00100, 1);
        add(0, 0, 1, 5'b01000, 5'b01000, 1);
        add(0, 1, 1, 5'b10001, 5'b00000, 0);
        add(0, 0, 1, 5'b10001, 5'b10000, 1);
        add(0, 0, 1, 5'b10001, 5'b00001, 1);
        add(0, 0, 1, 5'b00011, 5'b00010, 1);
        add(0, 0, 0, 5'b00000, 5'b00000, 1);
        add(1, 0, 0, 5'b00000, 5'b00000, 0);
        add(0, 0, 1, 5'b01001, 5'b00001, 1);
        add(0, 0, 1, 5'b01001, 5'b01000, 1);
        add(0, 0, 0, 5'b00000, 5'b00000, 1);
        add(0, 0, 1, 5'b00000, 5'b00000, 0);

        for (int n = 0; n < vq.size(); n++) begin
            x = vq[n];
            @(negedge clk);
            rst = x.r; flush = x.f; rob_ready = x.rdy; fu_valid = x.v;
            if (x.eb != '0) sbq.push_back(rec_of(x.eb));
            #1;
            chk($sformatf("bready[%0d]", n), 32'(fu_ready), 32'(x.eb));
            if (x.r) begin
                m_stall = 0;
                m_conf  = 0;
            end else begin
                if (pre_ov && !x.rdy && !x.f) m_stall = m_stall + 1;
                if (x.eb != '0 && $countones(x.v) > 1) m_conf = m_conf + 1;
            end
            @(posedge clk);
            #1;
            if (x.r) begin
                held = '{default: '0};
            end else if (x.eb != '0) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("sb_empty[%0d]", n), 32'd0, 32'd1);
                end else begin
                    held = sbq.pop_front();
                end
            end
            chk($sformatf("bvalid[%0d]", n), 32'(rob_valid), 32'(x.ev));
            chk($sformatf("grant[%0d]", n), 32'(rob_grant),
                x.ev ? 32'(held.g) : 32'd0);
            if (x.ev || x.r) begin
                chk($sformatf("data[%0d]", n), rob_data, held.d);
                chk($sformatf("tag[%0d]", n), 32'(rob_tag), 32'(held.t));
                chk($sformatf("id[%0d]", n), 32'(rob_id), 32'(held.id));
            end
`ifdef NCPU_WB_ARB_PERF_EN
            chk($sformatf("stall_cnt[%0d]", n), stall_cnt, m_stall);
            chk($sformatf("conflict_cnt[%0d]", n), conflict_cnt, m_conf);
`else
            chk($sformatf("stall_cnt[%0d]", n), stall_cnt, 32'd0);
            chk($sformatf("conflict_cnt[%0d]", n), conflict_cnt, 32'd0);
`endif
            pre_ov = x.ev;
        end

        // rst and flush together: flush blocks ready, reset values apply.
        @(negedge clk);
        rst = 1'b1; flush = 1'b1; rob_ready = 1'b1; fu_valid = 5'b10000;
        #1;
        chk("rstflush_bready", 32'(fu_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rstflush_bvalid", 32'(rob_valid), 32'd0);
        chk("rstflush_grant", 32'(rob_grant), 32'd0);
        chk("rstflush_data", rob_data, 32'd0);

        // Single request after reset: visible exactly one cycle later.
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; fu_valid = 5'b01000;
        cyc = 0;
        while (cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rob_valid) break;
        end
        chk("lat_bvalid", 32'(rob_valid), 32'd1);
        chk("lat_cycles", cyc, 32'd1);
        chk("lat_grant", 32'(rob_grant), 32'(5'b01000));
        chk("lat_data", rob_data, pd[3]);

        @(negedge clk);
        fu_valid = '0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
